// File: rtl/bird_physics.sv
// Bird vertical physics and game-state controller.
// Consumes debounced flap pulses, applies flap impulse, gravity, fall-speed
// cap, ceiling clamp and ground/collision death once per frame tick, and
// sequences the IDLE -> RUNNING -> DEAD -> IDLE game flow. All outputs are
// registered; every update is qualified by ce.
module bird_physics #(
    parameter int Y_WIDTH        = 10,
    parameter int VEL_WIDTH      = 6,
    parameter int SCREEN_HEIGHT  = 480,
    parameter int BIRD_HEIGHT    = 16,
    parameter int START_Y        = 232,
    parameter int GRAVITY        = 1,
    parameter int FLAP_SPEED     = 8,
    parameter int MAX_FALL_SPEED = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ce,
    input  logic                        frame_tick,
    input  logic                        flap,
    input  logic                        collision,
    output logic [Y_WIDTH-1:0]          bird_y,
    output logic signed [VEL_WIDTH-1:0] velocity,
    output logic [1:0]                  state,
    output logic                        game_over
);

    // Position math is done at Y_WIDTH+2 bits signed so neither the ceiling
    // underflow nor the floor overshoot can wrap.
    localparam int YW2 = Y_WIDTH + 2;

    localparam logic signed [YW2-1:0]   GRAV_V    = YW2'(GRAVITY);
    localparam logic signed [YW2-1:0]   FLAP_V    = YW2'(-FLAP_SPEED);
    localparam logic signed [YW2-1:0]   MAXF_V    = YW2'(MAX_FALL_SPEED);
    localparam logic signed [YW2-1:0]   FLOOR_V   = YW2'(SCREEN_HEIGHT - BIRD_HEIGHT);
    localparam logic [Y_WIDTH-1:0]      START_POS = Y_WIDTH'(START_Y);
    localparam logic [Y_WIDTH-1:0]      FLOOR_POS = Y_WIDTH'(SCREEN_HEIGHT - BIRD_HEIGHT);
    localparam logic signed [VEL_WIDTH-1:0] VEL_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DEAD    = 2'd2,
        ST_BAD     = 2'd3
    } state_t;

    state_t                        state_r, state_s;
    logic [Y_WIDTH-1:0]            bird_y_r, bird_y_s;
    logic signed [VEL_WIDTH-1:0]   velocity_r, velocity_s;
    logic                          flap_pending_r, flap_pending_s;
    logic                          game_over_r, game_over_s;

    logic signed [YW2-1:0]         vel_ext_s;
    logic signed [YW2-1:0]         vel_grav_s;
    logic signed [YW2-1:0]         vel_new_s;
    logic signed [YW2-1:0]         y_new_s;

    // Candidate velocity and position for a frame tick in RUNNING.
    always_comb begin
        vel_ext_s  = {{(YW2-VEL_WIDTH){velocity_r[VEL_WIDTH-1]}}, velocity_r};
        vel_grav_s = vel_ext_s + GRAV_V;
        if (flap_pending_r || flap) begin
            vel_new_s = FLAP_V;
        end else if (vel_grav_s > MAXF_V) begin
            vel_new_s = MAXF_V;
        end else begin
            vel_new_s = vel_grav_s;
        end
        y_new_s = $signed({2'b00, bird_y_r}) + vel_new_s;
    end

    // Next-state logic for the game FSM and the physics registers.
    always_comb begin
        state_s        = state_r;
        bird_y_s       = bird_y_r;
        velocity_s     = velocity_r;
        flap_pending_s = flap_pending_r;
        game_over_s    = game_over_r;
        if (ce) begin
            game_over_s = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    bird_y_s   = START_POS;
                    velocity_s = VEL_ZERO;
                    if (flap) begin
                        state_s        = ST_RUNNING;
                        flap_pending_s = 1'b1;
                    end else begin
                        flap_pending_s = 1'b0;
                    end
                end
                ST_RUNNING: begin
                    if (collision) begin
                        // Collision wins over a coincident tick: freeze in place.
                        state_s        = ST_DEAD;
                        game_over_s    = 1'b1;
                        flap_pending_s = 1'b0;
                    end else if (frame_tick) begin
                        flap_pending_s = 1'b0;
                        if (y_new_s[YW2-1]) begin
                            bird_y_s   = '0;
                            velocity_s = VEL_ZERO;
                        end else if (y_new_s >= FLOOR_V) begin
                            bird_y_s    = FLOOR_POS;
                            velocity_s  = VEL_ZERO;
                            state_s     = ST_DEAD;
                            game_over_s = 1'b1;
                        end else begin
                            bird_y_s   = y_new_s[Y_WIDTH-1:0];
                            velocity_s = vel_new_s[VEL_WIDTH-1:0];
                        end
                    end else if (flap) begin
                        flap_pending_s = 1'b1;
                    end else begin
                        flap_pending_s = flap_pending_r;
                    end
                end
                ST_DEAD: begin
                    // game_over_r marks the first DEAD cycle; a flap there
                    // is too early to count as a restart.
                    if (flap && !game_over_r) begin
                        state_s        = ST_IDLE;
                        bird_y_s       = START_POS;
                        velocity_s     = VEL_ZERO;
                        flap_pending_s = 1'b0;
                    end else begin
                        state_s = ST_DEAD;
                    end
                end
                default: begin
                    state_s        = ST_IDLE;
                    bird_y_s       = START_POS;
                    velocity_s     = VEL_ZERO;
                    flap_pending_s = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and physics registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            bird_y_r       <= START_POS;
            velocity_r     <= VEL_ZERO;
            flap_pending_r <= 1'b0;
            game_over_r    <= 1'b0;
        end else begin
            state_r        <= state_s;
            bird_y_r       <= bird_y_s;
            velocity_r     <= velocity_s;
            flap_pending_r <= flap_pending_s;
            game_over_r    <= game_over_s;
        end
    end

    assign bird_y    = bird_y_r;
    assign velocity  = velocity_r;
    assign state     = state_r;
    assign game_over = game_over_r;

endmodule
